// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front end of an ATM. Collects account number, PIN,
// menu choice, amount and optional transfer destination from a stream of key
// strobes, then presents them to the ATM core with a valid/ready request.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   key_code[3:0]     0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF ignored
//   key_valid         one-cycle strobe qualifying key_code
//   req_ready         ATM core accepts the presented request
//   acc_number[11:0]  account number
//   pin[3:0]          PIN digit
//   menu_option[2:0]  selected operation
//   amount[10:0]      transaction amount
//   dest_acc_number   transfer destination account (12 bits)
//   req_valid         request fields stable and valid
//   exit_pulse        one-cycle session exit
//   entry_error       one-cycle pulse on a rejected key
//   state[2:0]        current FSM state (debug)
//
// Optional feature: define KEYPAD_TIMEOUT_EN to enable an idle timeout of
// TIMEOUT_CYCLES cycles that acts as CANCEL outside S_ACC (frozen in S_ISSUE).
module atm_keypad_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    input  logic        req_ready,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    output logic [2:0]  menu_option,
    output logic [10:0] amount,
    output logic [11:0] dest_acc_number,
    output logic        req_valid,
    output logic        exit_pulse,
    output logic        entry_error,
    output logic [2:0]  state
);

    localparam int unsigned ACC_MAX = 4095;
    localparam int unsigned AMT_MAX = 2047;

    typedef enum logic [2:0] {
        S_ACC    = 3'd0,
        S_PIN    = 3'd1,
        S_MENU   = 3'd2,
        S_AMOUNT = 3'd3,
        S_DEST   = 3'd4,
        S_ISSUE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] acc_q, acc_d, dest_q, dest_d;
    logic [3:0]  pin_q, pin_d;
    logic [2:0]  menu_q, menu_d;
    logic [10:0] amt_q, amt_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req_valid_q, req_valid_d;
    logic        exit_q, exit_d;
    logic        err_q, err_d;

    logic        is_digit_c, is_enter_c, is_clear_c, cancel_c, timeout_c;
    logic [11:0] cur_val_c;
    logic [15:0] new_val_c;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle counter: cleared by any key, idle in S_ACC, frozen in S_ISSUE.
    assign timeout_c = !key_valid && (state_q != S_ACC) && (state_q != S_ISSUE)
                       && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_d = idle_q;
        if (key_valid || state_q == S_ACC || timeout_c) idle_d = '0;
        else if (state_q != S_ISSUE)                    idle_d = idle_q + IDLE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    assign timeout_c = 1'b0;
`endif

    assign is_digit_c = key_valid && (key_code <= 4'd9);
    assign is_enter_c = key_valid && (key_code == 4'hA);
    assign is_clear_c = key_valid && (key_code == 4'hB);
    assign cancel_c   = (key_valid && (key_code == 4'hC)) || timeout_c;

    // Field currently being accumulated and its value with the new digit appended.
    always_comb begin
        case (state_q)
            S_DEST:   cur_val_c = dest_q;
            S_AMOUNT: cur_val_c = {1'b0, amt_q};
            default:  cur_val_c = acc_q;
        endcase
    end
    assign new_val_c = 16'(cur_val_c) * 16'd10 + 16'(key_code);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dest_d  = dest_q;
        pin_d   = pin_q;
        menu_d  = menu_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        exit_d  = 1'b0;
        err_d   = 1'b0;

        if (cancel_c) begin
            exit_d  = 1'b1;
            acc_d   = '0;
            dest_d  = '0;
            pin_d   = '0;
            menu_d  = '0;
            amt_d   = '0;
            cnt_d   = '0;
            state_d = S_ACC;
        end else begin
            case (state_q)
                S_ACC, S_DEST: begin
                    if (is_digit_c) begin
                        if (cnt_q == 3'd4 || new_val_c > 16'(ACC_MAX)) begin
                            err_d = 1'b1;
                        end else begin
                            if (state_q == S_ACC) acc_d  = new_val_c[11:0];
                            else                  dest_d = new_val_c[11:0];
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (is_enter_c) begin
                        if (cnt_q == 3'd0) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = (state_q == S_ACC) ? S_PIN : S_ISSUE;
                        end
                    end else if (is_clear_c) begin
                        if (state_q == S_ACC) acc_d  = '0;
                        else                  dest_d = '0;
                        cnt_d = '0;
                    end
                end
                S_PIN: begin
                    if (is_digit_c) begin
                        if (cnt_q != 3'd0) begin
                            err_d = 1'b1;
                        end else begin
                            pin_d = key_code;
                            cnt_d = 3'd1;
                        end
                    end else if (is_enter_c) begin
                        if (cnt_q == 3'd0) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_MENU;
                        end
                    end else if (is_clear_c) begin
                        pin_d = '0;
                        cnt_d = '0;
                    end
                end
                S_MENU: begin
                    // A menu digit takes effect immediately; a new transaction
                    // starts with empty amount and destination fields.
                    if (is_digit_c) begin
                        case (key_code)
                            4'd3: begin
                                menu_d  = 3'd3;
                                state_d = S_ISSUE;
                            end
                            4'd4, 4'd5, 4'd6, 4'd7: begin
                                menu_d  = key_code[2:0];
                                amt_d   = '0;
                                dest_d  = '0;
                                cnt_d   = '0;
                                state_d = S_AMOUNT;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                S_AMOUNT: begin
                    if (is_digit_c) begin
                        // Overflow discards the whole amount, unlike account fields.
                        if (cnt_q == 3'd4 || new_val_c > 16'(AMT_MAX)) begin
                            err_d = 1'b1;
                            amt_d = '0;
                            cnt_d = '0;
                        end else begin
                            amt_d = new_val_c[10:0];
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (is_enter_c) begin
                        if (cnt_q == 3'd0) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = (menu_q == 3'd6) ? S_DEST : S_ISSUE;
                        end
                    end else if (is_clear_c) begin
                        amt_d = '0;
                        cnt_d = '0;
                    end
                end
                S_ISSUE: begin
                    if (req_valid_q && req_ready) state_d = S_MENU;
                end
                default: state_d = S_ACC;
            endcase
        end

        req_valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            dest_q      <= '0;
            pin_q       <= '0;
            menu_q      <= '0;
            amt_q       <= '0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            exit_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            dest_q      <= dest_d;
            pin_q       <= pin_d;
            menu_q      <= menu_d;
            amt_q       <= amt_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            exit_q      <= exit_d;
            err_q       <= err_d;
        end
    end

    assign acc_number      = acc_q;
    assign pin             = pin_q;
    assign menu_option     = menu_q;
    assign amount          = amt_q;
    assign dest_acc_number = dest_q;
    assign req_valid       = req_valid_q;
    assign exit_pulse      = exit_q;
    assign entry_error     = err_q;
    assign state           = 3'(state_q);

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Testbench for atm_keypad_entry: directed key sequences; expected events
// (entry errors, exits, accepted requests) go into a scoreboard queue that a
// negedge monitor drains as the DUT produces them. Field/state spot checks
// share the same counters.
module tb_atm_keypad_entry;

    localparam int EV_ERR  = 0;
    localparam int EV_EXIT = 1;
    localparam int EV_REQ  = 2;

    typedef struct {
        int kind;
        int acc;
        int pin;
        int menu;
        int amt;
        int dest;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        req_ready;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic [2:0]  menu_option;
    logic [10:0] amount;
    logic [11:0] dest_acc_number;
    logic        req_valid;
    logic        exit_pulse;
    logic        entry_error;
    logic [2:0]  state;

    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  sb[$];

    atm_keypad_entry #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .req_ready(req_ready), .acc_number(acc_number), .pin(pin),
        .menu_option(menu_option), .amount(amount), .dest_acc_number(dest_acc_number),
        .req_valid(req_valid), .exit_pulse(exit_pulse), .entry_error(entry_error),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int a, input int p, input int m,
                        input int am, input int d);
        ev_t e;
        e.kind = kind; e.acc = a; e.pin = p; e.menu = m; e.amt = am; e.dest = d;
        sb.push_back(e);
    endtask

    task automatic sb_match(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_REQ && e.kind == EV_REQ) begin
                check("req_acc",  int'(acc_number),      e.acc);
                check("req_pin",  int'(pin),             e.pin);
                check("req_menu", int'(menu_option),     e.menu);
                check("req_amt",  int'(amount),          e.amt);
                check("req_dest", int'(dest_acc_number), e.dest);
            end
        end
    endtask

    // Monitor: every error pulse, exit pulse and completed handshake is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (entry_error)            sb_match(EV_ERR);
            if (req_valid && req_ready) sb_match(EV_REQ);
            if (exit_pulse)             sb_match(EV_EXIT);
        end
    end

    // Each key is held for exactly one cycle; calls start at posedge+1.
    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic with_cancel);
        req_ready = 1'b1;
        if (with_cancel) begin
            key_code  = 4'hC;
            key_valid = 1'b1;
        end
        @(posedge clk); #1;
        req_ready = 1'b0;
        key_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_code = 4'h0; key_valid = 1'b0; req_ready = 1'b0;
        #23;
        check("rst_state", int'(state), 0);
        check("rst_acc", int'(acc_number), 0);
        check("rst_req_valid", int'(req_valid), 0);
        check("rst_exit", int'(exit_pulse), 0);
        check("rst_err", int'(entry_error), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Basic withdraw-with-balance session.
        press(4'd2); press(4'd1); press(4'd7); press(4'd8);
        check("acc_live", int'(acc_number), 2178);
        press(4'hA); press(4'd4); press(4'hA);
        check("state_menu", int'(state), 2);
        press(4'd5); press(4'd1); press(4'd0); press(4'd0); press(4'hA);
        push(EV_REQ, 2178, 4, 5, 100, 0);
        idle(3);
        check("req_held", int'(req_valid), 1);
        check("state_issue", int'(state), 5);
        press(4'd7); press(4'hB);
        check("issue_ignores_keys", int'(amount), 100);
        handshake(1'b0);
        check("req_dropped", int'(req_valid), 0);
        check("back_to_menu", int'(state), 2);

        // Amount overflow clears field; CLEAR; empty ENTER.
        press(4'd4);
        press(4'd2); press(4'd5); press(4'd0);
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'd0);
        check("amt_overflow_zero", int'(amount), 0);
        check("amt_overflow_state", int'(state), 3);
        press(4'd9); press(4'hB);
        check("amt_clear", int'(amount), 0);
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'hA);
        press(4'd1); press(4'd2); press(4'hA);
        push(EV_REQ, 2178, 4, 4, 12, 0);
        push(EV_EXIT, 0, 0, 0, 0, 0);
        idle(1);
        handshake(1'b1);
        check("cancel_hs_state", int'(state), 0);
        check("cancel_hs_acc", int'(acc_number), 0);
        check("cancel_hs_valid", int'(req_valid), 0);

        // Account limits, PIN limits, menu rejects, ignored codes, CANCEL.
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'hA);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'd5);
        press(4'hE);
        press(4'hA);
        check("acc_latched", int'(acc_number), 1234);
        press(4'd7);
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'd8);
        press(4'hA);
        check("pin_latched", int'(pin), 7);
        press(4'hA);
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'd9);
        check("menu_stays", int'(state), 2);
        push(EV_EXIT, 0, 0, 0, 0, 0);
        press(4'hC);
        check("cancel_state", int'(state), 0);
        check("cancel_acc", int'(acc_number), 0);
        check("cancel_pin", int'(pin), 0);
        check("cancel_menu", int'(menu_option), 0);

        // Transfer with destination overflow and CLEAR.
        press(4'd5); press(4'hA); press(4'd1); press(4'hA);
        press(4'd6); press(4'd5); press(4'd0); press(4'hA);
        check("state_dest", int'(state), 4);
        press(4'd5); press(4'd0); press(4'd0);
        push(EV_ERR, 0, 0, 0, 0, 0);
        press(4'd0);
        check("dest_unchanged", int'(dest_acc_number), 500);
        press(4'hB);
        press(4'd2); press(4'd8); press(4'd1); press(4'd6); press(4'hA);
        push(EV_REQ, 5, 1, 6, 50, 2816);
        idle(1);
        handshake(1'b0);

        // Reset while a balance request is pending.
        press(4'd3);
        check("balance_valid", int'(req_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(req_valid), 0);
        check("async_rst_state", int'(state), 0);
        check("async_rst_exit", int'(exit_pulse), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Idle session in S_MENU.
        press(4'd1); press(4'hA); press(4'd2); press(4'hA);
`ifdef KEYPAD_TIMEOUT_EN
        push(EV_EXIT, 0, 0, 0, 0, 0);
        idle(40);
        check("timeout_state", int'(state), 0);
`else
        idle(40);
        check("no_timeout_state", int'(state), 2);
`endif

        idle(2);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
